iterative_divider_core: RTL and testbench

Sequential unsigned integer divider (module `core`) computing quotient and remainder by restoring shift-subtract, one quotient bit per clock.
Sits as a compute leaf behind a simple start/done handshake. Small-area alternative to a combinational divider; latency is fixed at WIDTH+1 cycles.

---
 rtl/div_pkg.sv | 18 +
 rtl/div_step.sv | 33 +++
 rtl/iterative_divider_core.sv | 145 ++++++++++++++
 tb/tb_iterative_divider_core.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
// DIVIDER_SIGNED_EN (see iterative_divider_core) adds two's-complement support.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH_DEFAULT = 32;

  // Iteration counter must hold the value WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quot} left, trial-subtract the
// divisor from the widened remainder and keep the result only when non-negative.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quot,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quot
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_trial;
  logic             w_negative;

  assign w_shift = {i_rem, i_quot[WIDTH-1]};
  assign w_trial = {1'b0, w_shift} - {2'b00, i_divisor};
  // A kept trial is always below the divisor, so bit WIDTH set also means "does not fit".
  assign w_negative = w_trial[WIDTH+1] | w_trial[WIDTH];

  always_comb begin
    o_rem  = w_shift[WIDTH-1:0];
    o_quot = {i_quot[WIDTH-2:0], 1'b0};
    if (!w_negative) begin
      o_rem  = w_trial[WIDTH-1:0];
      o_quot = {i_quot[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/iterative_divider_core.sv
// Sequential restoring divider, one quotient bit per clock, start/done handshake.
// Define DIVIDER_SIGNED_EN to add the i_signed port and two's-complement division.
module iterative_divider_core
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
`ifdef DIVIDER_SIGNED_EN
  input  logic             i_signed,
`endif
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  div_state_t       r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_divisor;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_remOut;
  logic             r_busy;
  logic             r_done;
  logic             r_divByZero;

  logic [WIDTH-1:0] w_nextRem;
  logic [WIDTH-1:0] w_nextQuot;
  logic [WIDTH-1:0] w_dendMag;
  logic [WIDTH-1:0] w_divMag;
  logic [WIDTH-1:0] w_finalQuot;
  logic [WIDTH-1:0] w_finalRem;

`ifdef DIVIDER_SIGNED_EN
  logic r_negQuot;
  logic r_negRem;
  logic w_dendNeg;
  logic w_divNeg;

  assign w_dendNeg   = i_signed & i_dividend[WIDTH-1];
  assign w_divNeg    = i_signed & i_divisor[WIDTH-1];
  assign w_dendMag   = w_dendNeg ? (~i_dividend + 1'b1) : i_dividend;
  assign w_divMag    = w_divNeg  ? (~i_divisor  + 1'b1) : i_divisor;
  // Most-negative / -1 wraps back to most-negative here with a zero remainder.
  assign w_finalQuot = r_negQuot ? (~r_quot + 1'b1) : r_quot;
  assign w_finalRem  = r_negRem  ? (~r_rem  + 1'b1) : r_rem;
`else
  assign w_dendMag   = i_dividend;
  assign w_divMag    = i_divisor;
  assign w_finalQuot = r_quot;
  assign w_finalRem  = r_rem;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_quot    (r_quot),
    .i_divisor (r_divisor),
    .o_rem     (w_nextRem),
    .o_quot    (w_nextQuot)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_quot      <= '0;
      r_divisor   <= '0;
      r_count     <= '0;
      r_result    <= '0;
      r_remOut    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_divByZero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      r_negQuot   <= 1'b0;
      r_negRem    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_start) begin
            r_busy    <= 1'b1;
            r_divisor <= w_divMag;
            r_count   <= CNT_W'(WIDTH);
            if (i_divisor == '0) begin
              // Zero divisor skips iteration and reports the raw dividend.
              r_quot      <= '1;
              r_rem       <= i_dividend;
              r_divByZero <= 1'b1;
              r_state     <= DONE;
`ifdef DIVIDER_SIGNED_EN
              r_negQuot   <= 1'b0;
              r_negRem    <= 1'b0;
`endif
            end else begin
              r_quot      <= w_dendMag;
              r_rem       <= '0;
              r_divByZero <= 1'b0;
              r_state     <= BUSY;
`ifdef DIVIDER_SIGNED_EN
              r_negQuot   <= w_dendNeg ^ w_divNeg;
              r_negRem    <= w_dendNeg;
`endif
            end
          end
        end
        BUSY: begin
          r_rem   <= w_nextRem;
          r_quot  <= w_nextQuot;
          r_count <= r_count - 1'b1;
          if (r_count == CNT_W'(1)) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_result <= w_finalQuot;
          r_remOut <= w_finalRem;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign result        = r_result;
  assign o_remainder   = r_remOut;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_div_by_zero = r_divByZero;

endmodule

// File: tb/tb_iterative_divider_core.sv
// Directed self-checking bench for iterative_divider_core (WIDTH=32, unsigned build).
module tb_iterative_divider_core;

  localparam int W = 32;

  logic         i_clk;
  logic         i_rst_n;
  logic         i_start;
  logic [W-1:0] i_dividend;
  logic [W-1:0] i_divisor;
  logic [W-1:0] result;
  logic [W-1:0] o_remainder;
  logic         o_busy;
  logic         o_done;
  logic         o_div_by_zero;
`ifdef DIVIDER_SIGNED_EN
  logic         i_signed;
`endif

  int errors;
  int checks;

  iterative_divider_core #(.WIDTH(W)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_start       (i_start),
`ifdef DIVIDER_SIGNED_EN
    .i_signed      (i_signed),
`endif
    .i_dividend    (i_dividend),
    .i_divisor     (i_divisor),
    .result        (result),
    .o_remainder   (o_remainder),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_div_by_zero (o_div_by_zero)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Pulse start for one edge, then count negedges until o_done (0 on timeout).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    bit found;
    @(negedge i_clk);
    i_dividend = a;
    i_divisor  = b;
    i_start    = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    lat   = 0;
    found = 0;
    for (int k = 1; k <= 100 && !found; k++) begin
      @(negedge i_clk);
      if (o_done) begin
        lat   = k;
        found = 1;
      end
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    checks++;
    if ({result, o_remainder, o_busy, o_done, o_div_by_zero} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got res=%0h rem=%0h busy=%b done=%b dz=%b, expected all zero",
               result, o_remainder, o_busy, o_done, o_div_by_zero);
    end
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle: got busy=%b done=%b, expected 0 0", o_busy, o_done);
    end
  endtask

  task automatic test_basic();
    int lat;
    run_op(32'd5421, 32'd3, lat);
    checks++;
    if (lat !== 33) begin
      errors++;
      $display("[TB] FAIL basic_latency: got %0d expected 33", lat);
    end
    checks++;
    if (result !== 32'd1807 || o_remainder !== 32'd0 || o_div_by_zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_5421_3: got q=%0d r=%0d dz=%b expected q=1807 r=0 dz=0",
               result, o_remainder, o_div_by_zero);
    end
    @(negedge i_clk);
    checks++;
    if (o_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_pulse_width: got done=%b expected 0", o_done);
    end
  endtask

  task automatic test_hold();
    int lat;
    run_op(32'd113, 32'd2, lat);
    checks++;
    if (result !== 32'd56 || o_remainder !== 32'd1) begin
      errors++;
      $display("[TB] FAIL div_113_2: got q=%0d r=%0d expected q=56 r=1", result, o_remainder);
    end
    i_dividend = 32'd999;
    i_divisor  = 32'd4;
    repeat (6) @(negedge i_clk);
    checks++;
    if (result !== 32'd56 || o_remainder !== 32'd1 || o_done !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_outputs: got q=%0d r=%0d done=%b busy=%b expected q=56 r=1 done=0 busy=0",
               result, o_remainder, o_done, o_busy);
    end
  endtask

  task automatic test_boundary();
    int lat;
    run_op(32'hFFFF_FFFF, 32'd1, lat);
    checks++;
    if (result !== 32'hFFFF_FFFF || o_remainder !== 32'd0) begin
      errors++;
      $display("[TB] FAIL max_div_1: got q=%0h r=%0h expected q=ffffffff r=0", result, o_remainder);
    end
    run_op(32'd7, 32'd9, lat);
    checks++;
    if (result !== 32'd0 || o_remainder !== 32'd7) begin
      errors++;
      $display("[TB] FAIL small_div_large: got q=%0d r=%0d expected q=0 r=7", result, o_remainder);
    end
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    checks++;
    if (result !== 32'd1 || o_remainder !== 32'd0) begin
      errors++;
      $display("[TB] FAIL max_div_max: got q=%0d r=%0d expected q=1 r=0", result, o_remainder);
    end
    run_op(32'hFFFF_FFFF, 32'h8000_0000, lat);
    checks++;
    if (result !== 32'd1 || o_remainder !== 32'h7FFF_FFFF) begin
      errors++;
      $display("[TB] FAIL max_div_msb: got q=%0h r=%0h expected q=1 r=7fffffff", result, o_remainder);
    end
  endtask

  task automatic test_div_by_zero();
    int lat;
    run_op(32'd42, 32'd0, lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("[TB] FAIL dz_latency: got %0d expected 1", lat);
    end
    checks++;
    if (result !== 32'hFFFF_FFFF || o_remainder !== 32'd42 || o_div_by_zero !== 1'b1) begin
      errors++;
      $display("[TB] FAIL dz_values: got q=%0h r=%0d dz=%b expected q=ffffffff r=42 dz=1",
               result, o_remainder, o_div_by_zero);
    end
    run_op(32'd10, 32'd5, lat);
    checks++;
    if (result !== 32'd2 || o_remainder !== 32'd0 || o_div_by_zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL dz_clear: got q=%0d r=%0d dz=%b expected q=2 r=0 dz=0",
               result, o_remainder, o_div_by_zero);
    end
  endtask

  task automatic test_back_to_back();
    int  lat;
    bit  found;
    @(negedge i_clk);
    i_dividend = 32'd5421;
    i_divisor  = 32'd3;
    i_start    = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (5) @(negedge i_clk);
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_mid_op: got %b expected 1", o_busy);
    end
    i_dividend = 32'd100;
    i_divisor  = 32'd7;
    i_start    = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    lat   = 6;
    found = 0;
    for (int k = 7; k <= 100 && !found; k++) begin
      @(negedge i_clk);
      if (o_done) begin
        lat   = k;
        found = 1;
      end
    end
    checks++;
    if (!found || lat !== 33) begin
      errors++;
      $display("[TB] FAIL ignored_start_latency: got %0d found=%b expected 33", lat, found);
    end
    checks++;
    if (result !== 32'd1807 || o_remainder !== 32'd0) begin
      errors++;
      $display("[TB] FAIL ignored_start_result: got q=%0d r=%0d expected q=1807 r=0", result, o_remainder);
    end
    run_op(32'd100, 32'd7, lat);
    checks++;
    if (result !== 32'd14 || o_remainder !== 32'd2) begin
      errors++;
      $display("[TB] FAIL div_100_7: got q=%0d r=%0d expected q=14 r=2", result, o_remainder);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    int doneSeen;
    @(negedge i_clk);
    i_dividend = 32'd5421;
    i_divisor  = 32'd3;
    i_start    = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (9) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    checks++;
    if ({result, o_remainder, o_busy, o_done, o_div_by_zero} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid_op: got q=%0d r=%0d busy=%b done=%b dz=%b expected all zero",
               result, o_remainder, o_busy, o_done, o_div_by_zero);
    end
    @(negedge i_clk);
    i_rst_n  = 1'b1;
    doneSeen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge i_clk);
      if (o_done || o_busy) doneSeen++;
    end
    checks++;
    if (doneSeen !== 0) begin
      errors++;
      $display("[TB] FAIL aborted_no_done: got %0d active cycles expected 0", doneSeen);
    end
    run_op(32'd113, 32'd2, lat);
    checks++;
    if (lat !== 33 || result !== 32'd56 || o_remainder !== 32'd1) begin
      errors++;
      $display("[TB] FAIL after_reset_113_2: got lat=%0d q=%0d r=%0d expected lat=33 q=56 r=1",
               lat, result, o_remainder);
    end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    i_rst_n    = 1'b0;
    i_start    = 1'b0;
    i_dividend = '0;
    i_divisor  = '0;
`ifdef DIVIDER_SIGNED_EN
    i_signed   = 1'b0;
`endif
    test_reset();
    test_basic();
    test_hold();
    test_boundary();
    test_div_by_zero();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
